// File: rtl/oled_spi_ctrl_if.sv
// Byte handshake between a command/data source and the OLED SPI controller.
// The source offers a byte with valid; the controller takes it in any cycle where ready is high.
interface oled_spi_ctrl_if;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       byte_ready;

  modport master (
    output byte_valid,
    output byte_data,
    output byte_dc,
    input  byte_ready
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    input  byte_dc,
    output byte_ready
  );
endinterface

// File: rtl/oled_spi_ctrl.sv
// SSD1306 power sequencer (VDD -> RES -> VBAT up, reverse down) plus a write-only
// mode-3 SPI byte serializer, MSB first, with every output driven from a register.
module oled_spi_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int T_VDD   = 16000,
  parameter int T_RES   = 48,
  parameter int T_VBAT  = 1600000
) (
  input  logic           clk_16M,
  input  logic           reset_periph,
  input  logic           pwr_on,
  oled_spi_ctrl_if.slave bus,
  output logic           oled_ready,
  output logic           busy,
  output logic           oled_sclk,
  output logic           oled_sdin,
  output logic           oled_dc,
  output logic           oled_res_n,
  output logic           oled_vdd_n,
  output logic           oled_vbat_n
);

  localparam int T_MAX = (T_VDD > T_RES) ? ((T_VDD > T_VBAT) ? T_VDD : T_VBAT)
                                         : ((T_RES > T_VBAT) ? T_RES : T_VBAT);
  localparam int DLY_W = $clog2(T_MAX + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  localparam logic [DLY_W-1:0] DLY_ONE   = DLY_W'(1);
  localparam logic [DLY_W-1:0] VDD_LAST  = DLY_W'(T_VDD - 1);
  localparam logic [DLY_W-1:0] RES_LAST  = DLY_W'(T_RES - 1);
  localparam logic [DLY_W-1:0] VBAT_LAST = DLY_W'(T_VBAT - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  // Divider value one cycle before bit 0's high phase ends; READY is entered there
  // so the next byte can be accepted on the very edge that phase finishes.
  localparam logic [DIV_W-1:0] DIV_EXIT  = DIV_W'((CLK_DIV > 1) ? (CLK_DIV - 2) : 0);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_VDD_WAIT,
    ST_RES_LOW,
    ST_VBAT_WAIT,
    ST_READY,
    ST_SHIFT,
    ST_PD_WAIT
  } state_t;

  state_t           r_state;
  logic [DLY_W-1:0] r_dly;
  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_byte_ready;
  logic             r_oled_ready;
  logic             r_busy;
  logic             r_sclk;
  logic             r_sdin;
  logic             r_dc;
  logic             r_res_n;
  logic             r_vdd_n;
  logic             r_vbat_n;

  logic [2:0] w_bit_prev;
  logic       w_div_end;
  logic       w_last;

  // r_bit holds the index of the bit on sdin; it starts at 0 so the first
  // falling edge wraps it to 7 and bit 0 is the only one seen with r_bit == 0.
  assign w_bit_prev = r_bit - 3'd1;
  assign w_div_end  = (r_div == DIV_LAST);
  assign w_last     = (r_bit == 3'd0) &&
                      ((CLK_DIV == 1) ? (!r_sclk && w_div_end)
                                      : (r_sclk && (r_div == DIV_EXIT)));

  always_ff @(posedge clk_16M) begin
    if (reset_periph) begin
      r_state      <= ST_OFF;
      r_dly        <= '0;
      r_div        <= '0;
      r_bit        <= 3'd0;
      r_shift      <= 8'h00;
      r_byte_ready <= 1'b0;
      r_oled_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_sclk       <= 1'b1;
      r_sdin       <= 1'b0;
      r_dc         <= 1'b0;
      r_res_n      <= 1'b0;
      r_vdd_n      <= 1'b1;
      r_vbat_n     <= 1'b1;
    end else begin
      case (r_state)
        ST_OFF: begin
          if (pwr_on) begin
            r_vdd_n <= 1'b0;
            r_res_n <= 1'b1;
            r_busy  <= 1'b1;
            r_dly   <= '0;
            r_state <= ST_VDD_WAIT;
          end
        end

        ST_VDD_WAIT: begin
          if (!pwr_on) begin
            r_vbat_n <= 1'b1;
            r_dly    <= '0;
            r_state  <= ST_PD_WAIT;
          end else if (r_dly == VDD_LAST) begin
            r_res_n <= 1'b0;
            r_dly   <= '0;
            r_state <= ST_RES_LOW;
          end else begin
            r_dly <= r_dly + DLY_ONE;
          end
        end

        ST_RES_LOW: begin
          if (!pwr_on) begin
            r_vbat_n <= 1'b1;
            r_dly    <= '0;
            r_state  <= ST_PD_WAIT;
          end else if (r_dly == RES_LAST) begin
            r_res_n  <= 1'b1;
            r_vbat_n <= 1'b0;
            r_dly    <= '0;
            r_state  <= ST_VBAT_WAIT;
          end else begin
            r_dly <= r_dly + DLY_ONE;
          end
        end

        ST_VBAT_WAIT: begin
          if (!pwr_on) begin
            r_vbat_n <= 1'b1;
            r_dly    <= '0;
            r_state  <= ST_PD_WAIT;
          end else if (r_dly == VBAT_LAST) begin
            r_oled_ready <= 1'b1;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_dly        <= '0;
            r_state      <= ST_READY;
          end else begin
            r_dly <= r_dly + DLY_ONE;
          end
        end

        ST_READY: begin
          if (bus.byte_valid) begin
            r_shift      <= bus.byte_data;
            r_dc         <= bus.byte_dc;
            r_bit        <= 3'd0;
            r_div        <= DIV_LAST;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_SHIFT;
          end else if (!pwr_on) begin
            r_vbat_n     <= 1'b1;
            r_oled_ready <= 1'b0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_dly        <= '0;
            r_state      <= ST_PD_WAIT;
          end
        end

        ST_SHIFT: begin
          if (w_div_end) begin
            r_div <= '0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
              r_sdin <= r_shift[w_bit_prev];
              r_bit  <= w_bit_prev;
            end else begin
              r_sclk <= 1'b1;
            end
          end else begin
            r_div <= r_div + DIV_ONE;
          end
          if (w_last) begin
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_READY;
          end
        end

        ST_PD_WAIT: begin
          if (r_dly == VBAT_LAST) begin
            r_vdd_n <= 1'b1;
            r_res_n <= 1'b0;
            r_busy  <= 1'b0;
            r_dly   <= '0;
            r_state <= ST_OFF;
          end else begin
            r_dly <= r_dly + DLY_ONE;
          end
        end

        default: begin
          r_state <= ST_OFF;
        end
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign oled_ready     = r_oled_ready;
  assign busy           = r_busy;
  assign oled_sclk      = r_sclk;
  assign oled_sdin      = r_sdin;
  assign oled_dc        = r_dc;
  assign oled_res_n     = r_res_n;
  assign oled_vdd_n     = r_vdd_n;
  assign oled_vbat_n    = r_vbat_n;

endmodule
